// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges ID load-use bubbles with multi-cycle EX ops.
// Provides per-register stall bits, a flush strobe, and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
   parameter int MAC_LAT = 2,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stallreq,
   input  logic        ex_mc_start,
   input  logic        ex_mc_type,
   input  logic        flush_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        ex_mc_busy,
   output logic        ex_mc_done,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAC_INIT = CNT_W'(MAC_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);
   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // The start cycle counts as the first stall cycle, so RUN lasts LAT-1 cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (ex_mc_start && !flush_i) begin
               state_d = S_RUN;
               cnt_d   = ex_mc_type ? DIV_INIT : MAC_INIT;
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         // The finished instruction is still leaving EX, so its start level is ignored.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_o    = '0;
      flush_o    = 1'b0;
      ex_mc_busy = 1'b0;
      ex_mc_done = 1'b0;
      if (rst) begin
         ex_mc_busy = (state_q == S_RUN);
         ex_mc_done = (state_q == S_DONE);
         if (flush_i) begin
            flush_o = 1'b1;
         end else if (((state_q == S_IDLE) && ex_mc_start) || (state_q == S_RUN)) begin
            stall_o = STALL_EX;
         end else if (id_stallreq) begin
            stall_o = STALL_ID;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized traffic,
// all checked against a remaining-cycles model of the multi-cycle EX sequencing.
module tb_pipe_stall_ctrl;

   localparam int MAC_LAT = 2;
   localparam int DIV_LAT = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_stallreq = 1'b0;
   logic        ex_mc_start = 1'b0;
   logic        ex_mc_type = 1'b0;
   logic        flush_i = 1'b0;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic        ex_mc_busy;
   logic        ex_mc_done;
   logic [31:0] stall_cnt_o;

   pipe_stall_ctrl #(.MAC_LAT(MAC_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_stallreq (id_stallreq),
      .ex_mc_start (ex_mc_start),
      .ex_mc_type  (ex_mc_type),
      .flush_i     (flush_i),
      .stall_o     (stall_o),
      .flush_o     (flush_o),
      .ex_mc_busy  (ex_mc_busy),
      .ex_mc_done  (ex_mc_done),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: how many RUN cycles remain, whether a done cycle is due, stall total.
   int          m_run_left = 0;
   bit          m_done     = 1'b0;
   longint      m_cnt      = 0;
   logic [5:0]  e_stall;
   logic        e_flush, e_busy, e_done;
   logic [40:0] obs, expv;

   function automatic void model_eval();
      bit ex_hold;
      ex_hold = 1'b0;
      e_stall = 6'd0;
      e_flush = 1'b0;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      if (rst) begin
         if (m_done) begin
            e_done = 1'b1;
         end else if (m_run_left > 0) begin
            e_busy  = 1'b1;
            ex_hold = 1'b1;
         end else if (ex_mc_start) begin
            ex_hold = 1'b1;
         end
         if (flush_i)          e_flush = 1'b1;
         else if (ex_hold)     e_stall = 6'b001111;
         else if (id_stallreq) e_stall = 6'b000111;
      end
   endfunction

   function automatic void model_advance();
      model_eval();
      if (!rst) begin
         m_run_left = 0;
         m_done     = 1'b0;
         m_cnt      = 0;
      end else begin
         if (e_stall[0] && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_run_left > 0) begin
            if (flush_i) begin
               m_run_left = 0;
            end else begin
               m_run_left = m_run_left - 1;
               if (m_run_left == 0) m_done = 1'b1;
            end
         end else if (ex_mc_start && !flush_i) begin
            m_run_left = (ex_mc_type ? DIV_LAT : MAC_LAT) - 1;
         end
      end
   endfunction

   // Inputs are set just after a falling edge; sample settles outputs and builds both vectors.
   task automatic sample();
      #1;
      model_eval();
      obs  = {stall_cnt_o, stall_o, flush_o, ex_mc_busy, ex_mc_done};
      expv = {m_cnt[31:0], e_stall, e_flush, e_busy, e_done};
   endtask

   task automatic step();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic set_in(input logic id, input logic st, input logic ty, input logic fl);
      id_stallreq = id;
      ex_mc_start = st;
      ex_mc_type  = ty;
      flush_i     = fl;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         sample();
         n_cmp++;
         if (obs !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc%0d: got %h required %h", i, obs, 41'd0);
         end
         step();
      end
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      n_cmp++;
      if (obs !== 41'd0) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", obs, 41'd0);
      end
      step();
   endtask

   task automatic test_load_use();
      longint base;
      base = m_cnt;
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      n_cmp++;
      if (stall_o !== 6'b000111 || obs !== expv) begin
         n_fail++;
         $display("FAIL load_use_stall: got %h required %h", obs, expv);
      end
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      n_cmp++;
      if (stall_o !== 6'd0 || stall_cnt_o !== 32'(base + 1)) begin
         n_fail++;
         $display("FAIL load_use_after: got stall %b cnt %0d required 000000 cnt %0d",
                  stall_o, stall_cnt_o, base + 1);
      end
      step();
   endtask

   task automatic test_div();
      int     n_stall, n_busy, done_at;
      longint base;
      n_stall = 0;
      n_busy  = 0;
      done_at = -1;
      base    = m_cnt;
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DIV_LAT + 1; i++) begin
         sample();
         n_cmp++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL div_cycle%0d: got %h required %h", i, obs, expv);
         end
         if (stall_o == 6'b001111) n_stall++;
         if (ex_mc_busy) n_busy++;
         if (ex_mc_done && done_at < 0) done_at = i;
         step();
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      n_cmp++;
      if (n_stall != DIV_LAT || n_busy != DIV_LAT - 1 || done_at != DIV_LAT) begin
         n_fail++;
         $display("FAIL div_latency: got stall %0d busy %0d done_at %0d required %0d %0d %0d",
                  n_stall, n_busy, done_at, DIV_LAT, DIV_LAT - 1, DIV_LAT);
      end
      n_cmp++;
      if (stall_cnt_o !== 32'(base + DIV_LAT) || ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin
         n_fail++;
         $display("FAIL div_after: got cnt %0d busy %b done %b required cnt %0d busy 0 done 0",
                  stall_cnt_o, ex_mc_busy, ex_mc_done, base + DIV_LAT);
      end
      step();
   endtask

   task automatic test_mac_back_to_back();
      logic [5:0] want_stall, want_done, got_stall, got_done;
      want_stall = 6'b011011;
      want_done  = 6'b100100;
      got_stall  = '0;
      got_done   = '0;
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         sample();
         n_cmp++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL mac_b2b_cycle%0d: got %h required %h", i, obs, expv);
         end
         got_stall[i] = stall_o[0];
         got_done[i]  = ex_mc_done;
         step();
      end
      n_cmp++;
      if (got_stall !== want_stall || got_done !== want_done) begin
         n_fail++;
         $display("FAIL mac_b2b_pattern: got stall %b done %b required stall %b done %b",
                  got_stall, got_done, want_stall, want_done);
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_flush_mid_div();
      int dones;
      dones = 0;
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         sample();
         n_cmp++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL flush_div_pre%0d: got %h required %h", i, obs, expv);
         end
         step();
      end
      flush_i = 1'b1;
      sample();
      n_cmp++;
      if (flush_o !== 1'b1 || stall_o !== 6'd0 || ex_mc_busy !== 1'b1 || ex_mc_done !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_div_strobe: got flush %b stall %b busy %b done %b required 1 000000 1 0",
                  flush_o, stall_o, ex_mc_busy, ex_mc_done);
      end
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DIV_LAT + 4; i++) begin
         sample();
         if (ex_mc_done || ex_mc_busy) dones++;
         step();
      end
      n_cmp++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL flush_div_no_done: got %0d busy/done cycles required 0", dones);
      end
   endtask

   task automatic test_saturation();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.stall_cnt_q;
      m_cnt = 64'hFFFF_FFFE;
      sample();
      n_cmp++;
      if (stall_cnt_o !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL sat_preload: got %h required %h", stall_cnt_o, 32'hFFFF_FFFE);
      end
      id_stallreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         step();
      end
      id_stallreq = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         n_cmp++;
         if (stall_cnt_o !== 32'hFFFF_FFFF || obs !== expv) begin
            n_fail++;
            $display("FAIL sat_hold%0d: got %h required %h", i, stall_cnt_o, 32'hFFFF_FFFF);
         end
         step();
      end
      // Return to a small count so random traffic does not sit at the ceiling.
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         rst         = ($urandom_range(0, 299) != 0);
         id_stallreq = ($urandom_range(0, 3) == 0);
         ex_mc_start = ($urandom_range(0, 2) == 0);
         ex_mc_type  = ($urandom_range(0, 3) == 0);
         flush_i     = ($urandom_range(0, 24) == 0);
         sample();
         n_cmp++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %h required %h", i, obs, expv);
         end
         step();
      end
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_load_use();
      test_div();
      test_mac_back_to_back();
      test_flush_mid_div();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
